// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the raster pixel source.
// Geometry defaults match a 640x480 camera-like timing.
package pixel_stream_pkg;

  localparam int PIX_W = 8;
  localparam int CRD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_BLANK  = 160;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_BLANK  = 45;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             first;
    logic [CRD_W-1:0] x;
    logic [CRD_W-1:0] y;
  } pix_tag_t;

endpackage

// File: rtl/pixel_stream_pipe.sv
// Two-stage delay line aligning pixel tags with RAM read data.
// Coordinates and value hold their last valid contents between runs.
module pixel_stream_pipe
  import pixel_stream_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  pix_tag_t         tag_i,
  input  logic [PIX_W-1:0] rd_data,
  output logic [PIX_W-1:0] value,
  output logic [CRD_W-1:0] x,
  output logic [CRD_W-1:0] y,
  output logic             is_val,
  output logic             frame_start
);

  pix_tag_t         s1_d, s1_q;
  pix_tag_t         s2_d, s2_q;
  logic [PIX_W-1:0] value_d, value_q;

  always_comb begin
    s1_d       = tag_i;
    s2_d.valid = s1_q.valid;
    s2_d.first = s1_q.first;
    s2_d.x     = s1_q.valid ? s1_q.x : s2_q.x;
    s2_d.y     = s1_q.valid ? s1_q.y : s2_q.y;
    value_d    = s1_q.valid ? rd_data : value_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      value_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      value_q <= value_d;
    end
  end

  assign value       = value_q;
  assign x           = s2_q.x;
  assign y           = s2_q.y;
  assign is_val      = s2_q.valid;
  assign frame_start = s2_q.first;

endmodule

// File: rtl/pixel_stream_src.sv
// Raster pixel source: reads frame RAM in raster order and emits
// the pixel stream with horizontal and vertical blanking.
module pixel_stream_src
  import pixel_stream_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_BLANK  = DEF_V_BLANK,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  value,
  output logic [CRD_W-1:0]  x,
  output logic [CRD_W-1:0]  y,
  output logic              is_val,
  output logic              frame_start,
  output logic              busy
);

  localparam logic [CRD_W-1:0] HA_END = CRD_W'(H_ACTIVE - 1);
  localparam logic [CRD_W-1:0] HB_END = CRD_W'(H_BLANK - 1);
  localparam logic [CRD_W-1:0] VA_END = CRD_W'(V_ACTIVE - 1);
  localparam logic [CRD_W-1:0] VB_END = CRD_W'(V_BLANK - 1);
  localparam logic [CRD_W-1:0] LN_END = CRD_W'(H_ACTIVE + H_BLANK - 1);

  state_e            state_d, state_q;
  logic [CRD_W-1:0]  hcnt_d, hcnt_q;
  logic [CRD_W-1:0]  vcnt_d, vcnt_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              eol;
  logic              fend;
  pix_tag_t          tag;

  // VBLANK reuses hcnt as the line timer and vcnt as the blank-line count
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    addr_d  = addr_q;
    eol     = 1'b0;
    fend    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACTIVE;
          hcnt_d  = '0;
          vcnt_d  = '0;
          addr_d  = '0;
        end
      end
      ST_ACTIVE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (hcnt_q == HA_END) begin
          hcnt_d = '0;
          if (H_BLANK == 0) eol = 1'b1;
          else state_d = ST_HBLANK;
        end else begin
          hcnt_d = hcnt_q + CRD_W'(1);
        end
      end
      ST_HBLANK: begin
        if (hcnt_q == HB_END) begin
          hcnt_d = '0;
          eol    = 1'b1;
        end else begin
          hcnt_d = hcnt_q + CRD_W'(1);
        end
      end
      ST_VBLANK: begin
        if (hcnt_q == LN_END) begin
          hcnt_d = '0;
          if (vcnt_q == VB_END) fend = 1'b1;
          else vcnt_d = vcnt_q + CRD_W'(1);
        end else begin
          hcnt_d = hcnt_q + CRD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (eol) begin
      if (vcnt_q != VA_END) begin
        vcnt_d  = vcnt_q + CRD_W'(1);
        state_d = ST_ACTIVE;
      end else begin
        vcnt_d = '0;
        if (V_BLANK == 0) fend = 1'b1;
        else state_d = ST_VBLANK;
      end
    end

    // frame end goes straight to the next frame's first pixel
    if (fend) begin
      addr_d  = '0;
      hcnt_d  = '0;
      vcnt_d  = '0;
      state_d = enable ? ST_ACTIVE : ST_IDLE;
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      addr_q  <= addr_d;
    end
  end

  assign rd_en   = (state_q == ST_ACTIVE);
  assign rd_addr = addr_q;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    tag.valid = rd_en;
    tag.first = rd_en && (hcnt_q == '0) && (vcnt_q == '0);
    tag.x     = hcnt_q;
    tag.y     = vcnt_q;
  end

  pixel_stream_pipe u_pipe (
    .clk         (pclk),
    .rst_n       (reset),
    .tag_i       (tag),
    .rd_data     (rd_data),
    .value       (value),
    .x           (x),
    .y           (y),
    .is_val      (is_val),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_pixel_stream_src.sv
// Self-checking bench for pixel_stream_src on a 4x3 frame with
// 2-cycle line blanking and one blank line.
module tb_pixel_stream_src;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 1;
  localparam int LN = HA + HB;
  localparam int FP = LN * (VA + VB);

  logic       pclk;
  logic       reset;
  logic       enable;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] value;
  logic [9:0] x;
  logic [9:0] y;
  logic       is_val;
  logic       frame_start;
  logic       busy;

  int checks;
  int failures;
  int hold_x;
  int hold_y;
  int hold_v;

  pixel_stream_src #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .V_BLANK  (VB),
    .ADDR_W   (4)
  ) dut (
    .pclk        (pclk),
    .reset       (reset),
    .enable      (enable),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .value       (value),
    .x           (x),
    .y           (y),
    .is_val      (is_val),
    .frame_start (frame_start),
    .busy        (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // synchronous frame RAM: data = address + 0x10
  always @(posedge pclk)
    if (rd_en) rd_data <= 8'(rd_addr) + 8'h10;

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checks++;
    if ({rd_en, rd_addr, value, x, y, is_val, frame_start, busy} !== '0) begin
      failures++;
      $display("FAIL reset_state got rd_en=%0b rd_addr=%0d value=%0h x=%0d y=%0d is_val=%0b fs=%0b busy=%0b want all 0",
               rd_en, rd_addr, value, x, y, is_val, frame_start, busy);
    end
    enable = 1'b0;
    @(posedge pclk);
    #1 reset = 1'b1;
    hold_x = 0;
    hold_y = 0;
    hold_v = 0;
    repeat (4) begin
      @(negedge pclk);
      checks++;
      if (busy !== 1'b0 || is_val !== 1'b0 || rd_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle got busy=%0b is_val=%0b rd_en=%0b want 0", busy, is_val, rd_en);
      end
    end
    @(posedge pclk);
    #1;
  endtask

  // Runs nf frames; enable rises after gap idle cycles and drops in cycle drop_t.
  // t=0 is the cycle following the edge that sampled enable in IDLE.
  task automatic test_frames(input int nf, input int drop_t, input int gap, input string nm);
    int nval, nfs, fs_last;
    int r, u, f, px, py;
    logic e_rd, e_v, e_fs, e_busy;
    int e_addr;
    nval = 0;
    nfs = 0;
    fs_last = 0;
    repeat (gap) begin
      @(negedge pclk);
      checks++;
      if (busy !== 1'b0 || is_val !== 1'b0) begin
        failures++;
        $display("FAIL %s_gap got busy=%0b is_val=%0b want 0", nm, busy, is_val);
      end
      @(posedge pclk);
      #1;
    end
    enable = 1'b1;
    @(posedge pclk);
    #1;
    for (int t = 0; t < nf * FP + 6; t++) begin
      if (t == drop_t) enable = 1'b0;
      f = t / FP;
      r = t % FP;
      e_rd = (f < nf) && (r / LN < VA) && (r % LN < HA);
      e_addr = (r / LN) * HA + (r % LN);
      u = t - 2;
      e_v = 1'b0;
      px = 0;
      py = 0;
      if (u >= 0) begin
        px = (u % FP) % LN;
        py = (u % FP) / LN;
        e_v = (u / FP < nf) && (py < VA) && (px < HA);
      end
      e_fs = e_v && px == 0 && py == 0;
      e_busy = (t < nf * FP);
      if (e_v) begin
        hold_x = px;
        hold_y = py;
        hold_v = (py * HA + px + 16) % 256;
      end
      @(negedge pclk);
      checks++;
      if (rd_en !== e_rd || (e_rd && rd_addr !== 4'(e_addr))) begin
        failures++;
        $display("FAIL %s_rd t=%0d got rd_en=%0b addr=%0d want rd_en=%0b addr=%0d",
                 nm, t, rd_en, rd_addr, e_rd, e_addr);
      end
      checks++;
      if (is_val !== e_v || frame_start !== e_fs || busy !== e_busy) begin
        failures++;
        $display("FAIL %s_ctl t=%0d got is_val=%0b fs=%0b busy=%0b want %0b %0b %0b",
                 nm, t, is_val, frame_start, busy, e_v, e_fs, e_busy);
      end
      checks++;
      if (x !== 10'(hold_x) || y !== 10'(hold_y) || value !== 8'(hold_v)) begin
        failures++;
        $display("FAIL %s_pix t=%0d got x=%0d y=%0d value=%0h want x=%0d y=%0d value=%0h",
                 nm, t, x, y, value, hold_x, hold_y, hold_v);
      end
      if (is_val === 1'b1) nval++;
      if (frame_start === 1'b1) begin
        if (nfs > 0) begin
          checks++;
          if (t - fs_last != FP) begin
            failures++;
            $display("FAIL %s_period got %0d want %0d", nm, t - fs_last, FP);
          end
        end
        fs_last = t;
        nfs++;
      end
      @(posedge pclk);
      #1;
    end
    enable = 1'b0;
    checks++;
    if (nval != nf * HA * VA || nfs != nf) begin
      failures++;
      $display("FAIL %s_count got pixels=%0d frames=%0d want pixels=%0d frames=%0d",
               nm, nval, nfs, nf * HA * VA, nf);
    end
  endtask

  task automatic test_reset_mid_frame();
    enable = 1'b1;
    @(posedge pclk);
    #1;
    repeat (10) @(posedge pclk);
    #1;
    @(negedge pclk);
    checks++;
    if (is_val !== 1'b1 || x !== 10'd2 || y !== 10'd1 || value !== 8'h16) begin
      failures++;
      $display("FAIL mid_reset_pre got is_val=%0b x=%0d y=%0d value=%0h want 1 2 1 16",
               is_val, x, y, value);
    end
    reset = 1'b0;
    @(posedge pclk);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    hold_x = 0;
    hold_y = 0;
    hold_v = 0;
    @(negedge pclk);
    checks++;
    if ({rd_en, rd_addr, value, x, y, is_val, frame_start, busy} !== '0) begin
      failures++;
      $display("FAIL mid_reset_clear got rd_en=%0b rd_addr=%0d value=%0h x=%0d y=%0d is_val=%0b fs=%0b busy=%0b want all 0",
               rd_en, rd_addr, value, x, y, is_val, frame_start, busy);
    end
    repeat (10) begin
      @(posedge pclk);
      @(negedge pclk);
      checks++;
      if (is_val !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || x !== 10'd0 || value !== 8'd0) begin
        failures++;
        $display("FAIL mid_reset_idle got is_val=%0b busy=%0b rd_en=%0b x=%0d value=%0h want 0",
                 is_val, busy, rd_en, x, value);
      end
    end
    @(posedge pclk);
    #1;
    test_frames(1, 0, $urandom_range(0, 3), "restart");
  endtask

  initial begin
    int nf;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    test_reset();
    test_frames(1, 0, 3, "single");
    test_frames(1, 10, $urandom_range(0, 4), "drop_after_1_1");
    test_frames(1, $urandom_range(1, FP - 2), $urandom_range(0, 4), "drop_rand");
    nf = 3;
    test_frames(nf, (nf - 1) * FP + $urandom_range(0, FP - 2), 2, "wrap");
    nf = $urandom_range(2, 3);
    test_frames(nf, (nf - 1) * FP + $urandom_range(0, FP - 2), $urandom_range(0, 4), "back_to_back");
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pixel_stream_src.md
# pixel_stream_src

Raster pixel source that drives the `value`/`x`/`y`/`is_val` pixel stream consumed by the VGA buffer and downstream image blocks. It reads 8-bit pixels from an external synchronous frame RAM in raster order and emits them with camera-like horizontal and vertical blanking. It is the synthesizable transmitter end of the pixel-stream interface and replaces file-driven stimulus for on-board and system-level tests.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `H_BLANK`, 160: blank cycles after each active line.
- `V_ACTIVE`, 480: active lines per frame.
- `V_BLANK`, 45: blank lines per frame; each is `H_ACTIVE+H_BLANK` cycles.
- `ADDR_W`, 19: RAM address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE.
- `pclk` in 1: pixel clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `enable` in 1: start and continue streaming frames.
- `rd_en` out 1: RAM read strobe.
- `rd_addr` out ADDR_W: RAM read address, linear raster order.
- `rd_data` in 8: RAM read data, valid exactly 1 cycle after `rd_en` is sampled.
- `value` out 8: pixel value.
- `x` out 10: pixel column.
- `y` out 10: pixel row.
- `is_val` out 1: `value`/`x`/`y` valid this cycle.
- `frame_start` out 1: one-cycle pulse coincident with the pixel at x=0, y=0.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states are IDLE, ACTIVE, HBLANK, and VBLANK. Counters are `hcnt` (10b), `vcnt` (10b), and `addr` (ADDR_W).
- IDLE: if `enable`=1, go to ACTIVE with hcnt=vcnt=addr=0. Otherwise stay in IDLE.
- ACTIVE: assert `rd_en` and drive `rd_addr=addr`. Increment hcnt and addr.
  - At hcnt=H_ACTIVE-1, go to HBLANK and set hcnt=0.
  - If H_BLANK=0, treat HBLANK as zero-length and apply the end-of-line rule directly.
- HBLANK: after H_BLANK cycles, apply the end-of-line rule.
  - If vcnt<V_ACTIVE-1: increment vcnt and go to ACTIVE.
  - Otherwise: set vcnt=0 and go to VBLANK, or go to the frame-end rule if V_BLANK=0.
- VBLANK: count V_BLANK·(H_ACTIVE+H_BLANK) cycles, then apply the frame-end rule.
- Frame-end rule: set addr=0, hcnt=0, vcnt=0.
  - If `enable`=1, go to ACTIVE.
  - Otherwise go to IDLE.
- `enable` is sampled only in IDLE and at frame end. Deasserting it mid-frame completes the current frame.
- `rd_addr` comes from a running counter, not a multiplier. It wraps to 0 only at frame end.
- Pipeline stage 1 registers the issued (x=hcnt, y=vcnt, valid, first) alongside the RAM read.
- Stage 2 registers `value<=rd_data` together with x, y, `is_val`, and `frame_start` from stage 1.
- Outside active pixels, `is_val`=0 and x/y/value hold their last values.
- Reset values: `rd_en`=0, `rd_addr`=0, `value`=0, `x`=0, `y`=0, `is_val`=0, `frame_start`=0, `busy`=0. The FSM resets to IDLE.
- Reset mid-frame clears both pipeline stages, so no stale pixel is emitted afterwards.

## Timing
- Latency: a pixel issued on `rd_addr` in cycle n appears on `value`/`is_val` in cycle n+2.
- From `enable` rising in IDLE (sampled at edge e):
  - `rd_en`=1 in cycle e+1.
  - First `is_val` and `frame_start` in cycle e+3.
- `is_val` run length is H_ACTIVE, and runs are separated by exactly H_BLANK low cycles.
- Frame period is (H_ACTIVE+H_BLANK)·(V_ACTIVE+V_BLANK) cycles, with no extra cycle at frame end.
- Back-to-back frames: the first pixel of frame k+1 follows the last VBLANK cycle of frame k with no gap.
- If `reset` is low at edge r, all outputs hold reset values from cycle r+1 until the first edge at which `reset` is high.

## Structure
- Shared package `pixel_stream_pkg` holds:
  - the FSM state enum;
  - the pixel and coordinate width constants (8 and 10);
  - default geometry constants (640/160/480/45).
- The block is a single FSM plus counters, with one natural sub-module, `pixel_stream_pipe`. It is a 2-stage delay line carrying {valid, first, x, y} and capturing `rd_data`.

## Test plan
Bench parameters: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1. The bench RAM returns data = address + 8'h10.
- Single frame: `enable` pulsed high for one cycle, then low → exactly 12 `is_val` cycles. (x,y) follow (0,0)…(3,2), `value` is 10…1B, `frame_start` pulses once, then the block returns to IDLE with `busy`=0.
- Blanking: `enable` held high → per frame, `is_val` runs of 4 separated by 2 low cycles, then 8 low cycles. Frame period is exactly 24 cycles.
- Latency: `enable` high at edge 5 → `rd_addr`=0 with `rd_en` in cycle 6; `is_val`=1 with `value`=8'h10 in cycle 8.
- Mid-frame enable drop: `enable` goes low after pixel (1,1) → frame completes through (3,2) with no further pixels afterwards.
- Reset mid-frame: `reset` low for 1 cycle at pixel (2,1) → next cycle all outputs are 0. After `reset` returns high, no pixel is emitted until `enable` is seen; the following frame restarts at (0,0) with `rd_addr`=0.
- Wrap: 3 consecutive frames → `rd_addr` sequence 0..11 repeats each frame and `frame_start` is spaced 24 cycles apart.
